// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a bimodal predictor of saturating counters.
// Resolves RV32I conditional branches, flags mispredictions, trains the table and keeps statistics.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int INIT_CNT    = 1,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_is_branch,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              branchtaken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              illegal_br,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [CNT_BITS-1:0] bht [BHT_ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             act;
  logic             legal;
  logic             cond;
  logic             upd;

  // Word-aligned PCs: the two low bits never select an entry.
  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  logic pc_unused;
  assign pc_unused = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

  // Read of the registered table; a same-cycle update is not bypassed.
  assign f_pred_taken = bht[f_idx][CNT_BITS-1];

  assign act   = ex_valid & ex_is_branch & ~ex_stall;
  assign legal = (ex_funct3[2:1] != 2'b01);

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 <  ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign branchtaken = act & legal & cond;
  assign illegal_br  = act & ~legal;
  assign mispredict  = act & legal & (branchtaken != ex_pred_taken);
  assign redirect_pc = branchtaken ? ex_target : ex_pc + XLEN'(4);
  assign upd         = act & legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CNT_BITS'(INIT_CNT);
      end
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd) begin
      if (branchtaken) begin
        if (bht[ex_idx] != '1) bht[ex_idx] <= bht[ex_idx] + CNT_BITS'(1);
      end else begin
        if (bht[ex_idx] != '0) bht[ex_idx] <= bht[ex_idx] - CNT_BITS'(1);
      end
      if (stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispred != '1)) stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a vector table for resolution logic plus
// hand sequences for training, saturation, stall, aliasing and reset behaviour.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        ex_valid, ex_stall, ex_is_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target;
  logic        branchtaken, mispredict, illegal_br;
  logic [31:0] redirect_pc, stat_branches, stat_mispred;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .branchtaken(branchtaken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .illegal_br(illegal_br), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt;
    logic        pred, valid, isbr, stall;
    logic        e_taken, e_mis, e_ill;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                       input logic valid, input logic isbr, input logic stall);
    ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; ex_valid = valid; ex_is_branch = isbr; ex_stall = stall;
  endtask

  // Apply a branch one cycle: inputs set just after a rising edge, outputs sampled on the falling edge.
  task automatic step(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                      input logic stall);
    @(posedge clk); #1;
    drive(f3, rs1, rs2, pc, tgt, pred, 1'b1, 1'b1, stall);
    @(negedge clk);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive(3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pred_at(input string nm, input logic [31:0] pc, input logic exp);
    f_pc = pc;
    #1;
    chk(nm, {31'b0, f_pred_taken}, {31'b0, exp});
  endtask

  task automatic stats(input string nm);
    chk({nm, "_br"}, stat_branches, exp_br);
    chk({nm, "_mp"}, stat_mispred, exp_mp);
  endtask

  initial begin
    //            f3      rs1           rs2       pc            tgt       pred vld br  stl  tk mis ill rd
    vecs[0]  = '{3'b000, 32'h5,        32'h5,    32'h1000,     32'h2000, 0,  1, 1, 0,  1, 1, 0, 32'h2000};
    vecs[1]  = '{3'b000, 32'h5,        32'h6,    32'h1000,     32'h2000, 0,  1, 1, 0,  0, 0, 0, 32'h1004};
    vecs[2]  = '{3'b001, 32'h5,        32'h6,    32'h1000,     32'h2000, 1,  1, 1, 0,  1, 0, 0, 32'h2000};
    vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'h1,    32'h1000,     32'h2000, 0,  1, 1, 0,  1, 1, 0, 32'h2000};
    vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h1,    32'h1000,     32'h2000, 1,  1, 1, 0,  0, 1, 0, 32'h1004};
    vecs[5]  = '{3'b110, 32'hFFFFFFFF, 32'h1,    32'h1000,     32'h2000, 1,  1, 1, 0,  0, 1, 0, 32'h1004};
    vecs[6]  = '{3'b111, 32'hFFFFFFFF, 32'h1,    32'h1000,     32'h2000, 0,  1, 1, 0,  1, 1, 0, 32'h2000};
    vecs[7]  = '{3'b100, 32'h7,        32'h7,    32'h1000,     32'h2000, 0,  1, 1, 0,  0, 0, 0, 32'h1004};
    vecs[8]  = '{3'b101, 32'h7,        32'h7,    32'h1000,     32'h2000, 1,  1, 1, 0,  1, 0, 0, 32'h2000};
    vecs[9]  = '{3'b110, 32'h0,        32'h1,    32'h1000,     32'h2000, 0,  1, 1, 0,  1, 1, 0, 32'h2000};
    vecs[10] = '{3'b010, 32'h5,        32'h5,    32'h1000,     32'h2000, 1,  1, 1, 0,  0, 0, 1, 32'h1004};
    vecs[11] = '{3'b011, 32'h5,        32'h6,    32'h1000,     32'h2000, 0,  1, 1, 0,  0, 0, 1, 32'h1004};
    vecs[12] = '{3'b000, 32'h5,        32'h5,    32'h1000,     32'h2000, 0,  0, 1, 0,  0, 0, 0, 32'h1004};
    vecs[13] = '{3'b000, 32'h5,        32'h5,    32'h1000,     32'h2000, 0,  1, 1, 1,  0, 0, 0, 32'h1004};
    vecs[14] = '{3'b000, 32'h5,        32'h5,    32'h1000,     32'h2000, 0,  1, 0, 0,  0, 0, 0, 32'h1004};
    vecs[15] = '{3'b000, 32'h1,        32'h2,    32'hFFFFFFFC, 32'h2000, 1,  1, 1, 0,  0, 1, 0, 32'h0};
    vecs[16] = '{3'b010, 32'h5,        32'h5,    32'h1000,     32'h2000, 0,  1, 1, 1,  0, 0, 0, 32'h1004};

    rst_n = 1'b0;
    f_pc = 32'h100;
    drive(3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Vector table: combinational resolution, with a running model of the statistics.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].tgt, vecs[i].pred,
            vecs[i].valid, vecs[i].isbr, vecs[i].stall);
      @(negedge clk);
      chk($sformatf("v%0d_taken", i), {31'b0, branchtaken}, {31'b0, vecs[i].e_taken});
      chk($sformatf("v%0d_mis", i),   {31'b0, mispredict},  {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_ill", i),   {31'b0, illegal_br},  {31'b0, vecs[i].e_ill});
      chk($sformatf("v%0d_rd", i),    redirect_pc,          vecs[i].e_rd);
      if (vecs[i].valid && vecs[i].isbr && !vecs[i].stall && !vecs[i].e_ill) exp_br++;
      if (vecs[i].e_mis) exp_mp++;
    end
    idle();
    stats("vec_stats");

    // Reset state.
    do_reset();
    exp_br = 0; exp_mp = 0;
    stats("rst");
    for (int i = 0; i < 8; i++) pred_at($sformatf("rst_pred%0d", i), 32'h100 + 32'(i * 4), 1'b0);
    f_pc = 32'h100;

    // beq taken, predicted not taken.
    step(3'b000, 5, 5, 32'h100, 32'h80, 1'b0, 1'b0);
    chk("beq_taken", {31'b0, branchtaken}, 32'd1);
    chk("beq_mis", {31'b0, mispredict}, 32'd1);
    chk("beq_rd", redirect_pc, 32'h80);
    idle();
    exp_br = 1; exp_mp = 1;
    pred_at("beq_pred_after", 32'h100, 1'b1);
    stats("beq");

    // Saturation at 0x104: 1 -> 2 -> 3 -> 3 -> 3, then down to 2 and 1.
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 1, 2, 32'h104, 32'h40, 1'b1, 1'b0);
      chk($sformatf("sat_mis%0d", i), {31'b0, mispredict}, 32'd0);
    end
    idle();
    exp_br += 4;
    pred_at("sat_pred", 32'h104, 1'b1);
    step(3'b001, 3, 3, 32'h104, 32'h40, 1'b1, 1'b0);
    chk("nt_rd", redirect_pc, 32'h108);
    idle();
    exp_br += 1; exp_mp += 1;
    pred_at("dec1_pred", 32'h104, 1'b1);
    step(3'b001, 3, 3, 32'h104, 32'h40, 1'b1, 1'b0);
    idle();
    exp_br += 1; exp_mp += 1;
    pred_at("dec2_pred", 32'h104, 1'b0);
    stats("sat");

    // Illegal funct3 twice must not train 0x108; one taken then lifts it to 2.
    step(3'b010, 5, 5, 32'h108, 32'h40, 1'b1, 1'b0);
    chk("ill_flag", {31'b0, illegal_br}, 32'd1);
    chk("ill_taken", {31'b0, branchtaken}, 32'd0);
    step(3'b011, 5, 5, 32'h108, 32'h40, 1'b1, 1'b0);
    idle();
    stats("ill");
    step(3'b000, 5, 5, 32'h108, 32'h40, 1'b0, 1'b0);
    idle();
    exp_br += 1; exp_mp += 1;
    pred_at("ill_then_taken", 32'h108, 1'b1);

    // Stalled branch is ignored, then counted once when it proceeds.
    step(3'b000, 9, 9, 32'h10C, 32'h40, 1'b0, 1'b1);
    chk("stall_mis", {31'b0, mispredict}, 32'd0);
    idle();
    pred_at("stall_pred", 32'h10C, 1'b0);
    stats("stall");
    step(3'b000, 9, 9, 32'h10C, 32'h40, 1'b0, 1'b0);
    chk("unstall_mis", {31'b0, mispredict}, 32'd1);
    idle();
    exp_br += 1; exp_mp += 1;
    pred_at("unstall_pred", 32'h10C, 1'b1);
    stats("unstall");

    // Alias 0x100/0x200: read returns pre-update value, new value next cycle.
    f_pc = 32'h100;
    step(3'b001, 1, 1, 32'h200, 32'h40, 1'b0, 1'b0);
    chk("alias_old", {31'b0, f_pred_taken}, 32'd1);
    idle();
    exp_br += 1;
    pred_at("alias_new", 32'h100, 1'b0);
    stats("alias");

    // Reset during a qualifying update discards it; combinational outputs still follow inputs.
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(3'b000, 5, 5, 32'h104, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_comb_taken", {31'b0, branchtaken}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_br = 0; exp_mp = 0;
    stats("midrst");
    pred_at("midrst_104", 32'h104, 1'b0);
    pred_at("midrst_108", 32'h108, 1'b0);
    pred_at("midrst_10C", 32'h10C, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Execute-stage branch resolution unit with an integrated bimodal predictor. It evaluates all six RV32I conditional-branch conditions from raw operands and flags mispredictions against the fetch-stage guess. It also computes the redirect PC and trains a table of saturating counters indexed by PC. It sits between fetch, which reads the prediction, and execute, which resolves the branch and updates the table. It drives the pipeline flush/redirect path.

## Interface
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, number of predictor entries; power of two, ≥2
- CNT_BITS, 2, width of each saturating counter (≥1)
- INIT_CNT, 1, counter reset value (weakly not-taken for 2-bit)
- STAT_W, 32, width of the statistics counters

- clk  in  1  clock
- rst_n  in  1  reset, synchronous and active-low; one clock; reset is synchronous and active-low
- f_pc  in  XLEN  fetch PC to predict
- f_pred_taken  out  1  prediction for f_pc: counter MSB
- ex_valid  in  1  instruction in EX is valid
- ex_stall  in  1  EX held this cycle; suppresses all state updates
- ex_is_branch  in  1  instruction is a conditional branch (B-type)
- ex_funct3  in  3  branch condition
- ex_rs1, ex_rs2  in  XLEN  operands
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- branchtaken  out  1  resolved outcome
- mispredict  out  1  outcome ≠ ex_pred_taken; requests a flush
- redirect_pc  out  XLEN  correct next PC
- illegal_br  out  1  funct3 of 010 or 011 on a valid branch
- stat_branches  out  STAT_W  resolved-branch count
- stat_mispred  out  STAT_W  misprediction count

## Operation
- Index IDX_W = log2(BHT_ENTRIES). Entry index = pc[IDX_W+1:2].
- Prediction: f_pred_taken = MSB of the counter at index(f_pc). It is a combinational read of the registered table.
- Resolution is qualified by `act = ex_valid & ex_is_branch & ~ex_stall`. Conditions by ex_funct3:
  - 000: taken when rs1 == rs2
  - 001: taken when rs1 != rs2
  - 100: taken when rs1 < rs2, signed
  - 101: taken when rs1 ≥ rs2, signed
  - 110: taken when rs1 < rs2, unsigned
  - 111: taken when rs1 ≥ rs2, unsigned
  - 010/011: not taken, and illegal_br = 1
- When act = 0: branchtaken, mispredict and illegal_br are all 0.
- mispredict = act & legal funct3 & (branchtaken ≠ ex_pred_taken).
- redirect_pc = ex_target if branchtaken, otherwise ex_pc + 4 (mod 2^XLEN). It is valid only while mispredict = 1.
- Table update on a clock edge with act and legal funct3:
  - taken: counter at index(ex_pc) increments, saturating at 2^CNT_BITS−1
  - not taken: counter decrements, saturating at 0
  - illegal funct3 causes no update.
- Statistics, updated under the same qualification:
  - stat_branches increments on every such branch.
  - stat_mispred increments when mispredict is also 1.
  - Both saturate at all-ones; neither wraps.
- When the same index is read and updated in the same cycle, the read returns the pre-update value. There is no bypass.

## Timing
- Prediction and resolution outputs are combinational, with zero-cycle latency.
- Table and statistics updates become visible on the cycle after the qualifying edge.
- Reset (rst_n low at a clk edge) sets every counter to INIT_CNT and both statistics to 0. It overrides any simultaneous update.
- Reset mid-stream discards the in-flight update from that cycle.
- While rst_n is low, f_pred_taken reflects INIT_CNT's MSB from the next cycle. Combinational outputs still follow their inputs.
- ex_stall = 1 suppresses mispredict, table and statistics updates. The same branch is therefore counted and trained exactly once, on its non-stalled cycle.

## Test plan
- Reset, then f_pc = 0x100 → f_pred_taken = 0. Both statistics read 0, all counters = 1.
- beq at ex_pc = 0x100, rs1 = rs2 = 5, ex_pred_taken = 0, ex_target = 0x80 → branchtaken = 1, mispredict = 1, redirect_pc = 0x80. Next cycle f_pred_taken(0x100) = 1, stat_mispred = 1.
- blt with rs1 = 0xFFFFFFFF, rs2 = 1 → taken. bltu with the same operands → not taken, and redirect_pc = ex_pc + 4 when predicted taken.
- Four taken resolutions at one PC → counter saturates at 3. Then one not-taken → counter = 2, prediction still taken.
- ex_funct3 = 010 with ex_valid = 1 → illegal_br = 1, branchtaken = 0, no counter or statistics change. The same branch with ex_stall = 1 → mispredict = 0 and no update.
- f_pc and ex_pc alias (0x100 and 0x200 with 64 entries) with an update in the same cycle → the prediction shows the old value and the new value on the next cycle. Assert rst_n low during an update → all state reads back at its reset value.
